fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Two-requester round-robin arbiter that feeds a single downstream FIFO write
// port. A requester owns the port for a burst of at most BURST_LEN accepted
// writes. The grant ends early when the requester drops its request. Ownership
// passes directly to the other requester when it is waiting. A full FIFO
// stalls the current owner without consuming any of its burst.
//
// Parameters
//   DATA_W     width of requester data and FIFO write data
//   DEPTH      downstream FIFO capacity in words
//   BURST_LEN  maximum accepted writes per grant (1..15)
//
// Ports
//   clk                 rising-edge clock
//   reset               synchronous, active-low reset
//   req0/req1           write requests, held high while data0/data1 is valid
//   data0/data1         requester write data
//   ack0/ack1           high in the cycle the requester's word is written
//   fifo_cnt            downstream FIFO occupancy (values >= DEPTH mean full)
//   fifo_wr_en          FIFO write enable
//   fifo_wdata          FIFO write data (zero when no requester owns the port)
//   grant               one-hot owner: 01 = requester 0, 10 = requester 1
//   wr_count0/1         per-requester accepted-write statistics
//
// Optional feature: define FIFO_WR_ARB_STATS_EN to build saturating 16-bit
// write counters behind wr_count0/1. Without it both outputs read zero and no
// counter flops exist.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              ack0,
  output logic              ack1,
  input  logic [4:0]        fifo_cnt,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wdata,
  output logic [1:0]        grant,
  output logic [15:0]       wr_count0,
  output logic [15:0]       wr_count1
);

  // The state encoding equals the grant encoding, so grant comes straight
  // from the state register.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_e;

  localparam logic [31:0] DEPTH_U   = 32'(DEPTH);
  localparam logic [3:0]  BURST_MAX = 4'(BURST_LEN);

  state_e     state_q, state_d;
  logic       ptr_q, ptr_d;      // 0 favours requester 0 when both wait in IDLE
  logic [3:0] burst_q, burst_d;  // accepted writes within the current grant

  logic       fifo_full;
  logic       own_req;
  logic       other_req;
  logic       wr_en;
  logic [3:0] burst_inc;
  logic       release_grant;

  // Occupancy at or above DEPTH is full, including out-of-range counts.
  assign fifo_full = ({27'd0, fifo_cnt} >= DEPTH_U);

  assign own_req   = ((state_q == OWN0) && req0) || ((state_q == OWN1) && req1);
  assign other_req = ((state_q == OWN0) && req1) || ((state_q == OWN1) && req0);

  // NOTE: the write strobe is gated by reset as well as by the state, because
  // a synchronous reset only takes effect at the next edge; without the gate
  // the reset cycle itself could still write a word mid-burst.
  assign wr_en = reset && own_req && !fifo_full;

  assign burst_inc = burst_q + 4'd1;

  // The write that completes the burst releases in the same cycle it is
  // accepted; a dropped request releases with no write in that cycle.
  assign release_grant = !own_req || (wr_en && (burst_inc == BURST_MAX));

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        burst_d = '0;
        if (req0 && (!req1 || !ptr_q)) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (wr_en) begin
          burst_d = burst_inc;
        end
        if (release_grant) begin
          burst_d = '0;
          // Point away from the requester that just finished.
          ptr_d   = (state_q == OWN0);
          if (other_req) begin
            state_d = (state_q == OWN0) ? OWN1 : OWN0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        burst_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
    end
  end

  assign grant      = reset ? 2'(state_q) : 2'b00;
  assign fifo_wr_en = wr_en;
  assign ack0       = wr_en && (state_q == OWN0);
  assign ack1       = wr_en && (state_q == OWN1);

  always_comb begin
    fifo_wdata = '0;
    if (reset) begin
      case (state_q)
        OWN0:    fifo_wdata = data0;
        OWN1:    fifo_wdata = data1;
        default: fifo_wdata = '0;
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] wr_count0_q, wr_count0_d;
  logic [15:0] wr_count1_q, wr_count1_d;

  // Saturating counters: they stop at all-ones rather than wrap.
  always_comb begin
    wr_count0_d = wr_count0_q;
    wr_count1_d = wr_count1_q;
    if (ack0 && (wr_count0_q != 16'hFFFF)) begin
      wr_count0_d = wr_count0_q + 16'd1;
    end
    if (ack1 && (wr_count1_q != 16'hFFFF)) begin
      wr_count1_d = wr_count1_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_count0_q <= '0;
      wr_count1_q <= '0;
    end else begin
      wr_count0_q <= wr_count0_d;
      wr_count1_q <= wr_count1_d;
    end
  end

  assign wr_count0 = wr_count0_q;
  assign wr_count1 = wr_count1_q;
`else
  assign wr_count0 = '0;
  assign wr_count1 = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Self-checking bench for fifo_wr_arbiter. Each requester is modelled as a
// queue of pending words: it requests while its queue is non-empty (and its
// enable is set) and presents the head word. A reference model tracks the
// owner, the writes served in the current grant, and the requester favoured on
// the next contention. It predicts every output each cycle. Directed
// scenarios are followed by a long randomized run.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 16;
  localparam int BURST_LEN = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0, req1;
  logic [DATA_W-1:0] data0, data1;
  logic              ack0, ack1;
  logic [4:0]        fifo_cnt;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_wdata;
  logic [1:0]        grant;
  logic [15:0]       wr_count0, wr_count1;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .BURST_LEN(BURST_LEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .data0     (data0),
    .data1     (data1),
    .ack0      (ack0),
    .ack1      (ack1),
    .fifo_cnt  (fifo_cnt),
    .fifo_wr_en(fifo_wr_en),
    .fifo_wdata(fifo_wdata),
    .grant     (grant),
    .wr_count0 (wr_count0),
    .wr_count1 (wr_count1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Pending words for each requester.
  logic [DATA_W-1:0] wq0[$];
  logic [DATA_W-1:0] wq1[$];

  // Reference model: -1 means nobody owns the port.
  int m_own    = -1;
  int m_served = 0;
  int m_fav    = 0;
  int m_cnt[2] = '{0, 0};

  // Per-phase observation records (index = cycle within the phase).
  int obs_g[$];
  int obs_wr[$];
  int ack_tot0, ack_tot1;

  task automatic clear_obs();
    obs_g.delete();
    obs_wr.delete();
    ack_tot0 = 0;
    ack_tot1 = 0;
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  // Called just after a rising edge.
  task automatic tick(input bit en0, input bit en1, input int fc, input bit rst_n);
    bit                r[2];
    logic [DATA_W-1:0] d[2];
    bit                full, wr, rel;
    int                exp_grant, other;
    logic [DATA_W-1:0] exp_wdata;
    logic [15:0]       exp_wc0, exp_wc1;

    r[0] = en0 && (wq0.size() > 0);
    r[1] = en1 && (wq1.size() > 0);
    d[0] = r[0] ? wq0[0] : DATA_W'($urandom);
    d[1] = r[1] ? wq1[0] : DATA_W'($urandom);

    reset    = rst_n;
    req0     = r[0];
    req1     = r[1];
    data0    = d[0];
    data1    = d[1];
    fifo_cnt = 5'(fc);

    @(negedge clk);
    full      = (fc >= DEPTH);
    wr        = rst_n && (m_own >= 0) && r[m_own] && !full;
    exp_grant = (!rst_n || m_own < 0) ? 0 : (1 << m_own);
    exp_wdata = (!rst_n || m_own < 0) ? '0 : d[m_own];
`ifdef FIFO_WR_ARB_STATS_EN
    exp_wc0 = 16'(m_cnt[0]);
    exp_wc1 = 16'(m_cnt[1]);
`else
    exp_wc0 = '0;
    exp_wc1 = '0;
`endif
    check("grant",      32'(grant),      32'(exp_grant));
    check("fifo_wr_en", 32'(fifo_wr_en), 32'(wr));
    check("ack0",       32'(ack0),       32'(wr && m_own == 0));
    check("ack1",       32'(ack1),       32'(wr && m_own == 1));
    check("fifo_wdata", 32'(fifo_wdata), 32'(exp_wdata));
    check("wr_count0",  32'(wr_count0),  32'(exp_wc0));
    check("wr_count1",  32'(wr_count1),  32'(exp_wc1));

    obs_g.push_back(int'(grant));
    obs_wr.push_back(int'(fifo_wr_en));
    ack_tot0 += int'(ack0);
    ack_tot1 += int'(ack1);

    // Advance the model to the state after the coming rising edge.
    if (!rst_n) begin
      m_own    = -1;
      m_served = 0;
      m_fav    = 0;
      m_cnt    = '{0, 0};
    end else if (m_own < 0) begin
      if (r[0] && r[1]) m_own = m_fav;
      else if (r[0])    m_own = 0;
      else if (r[1])    m_own = 1;
      m_served = 0;
    end else begin
      rel = !r[m_own];
      if (wr) begin
        m_served++;
        if (m_cnt[m_own] < 65535) m_cnt[m_own]++;
        if (m_own == 0) void'(wq0.pop_front());
        else            void'(wq1.pop_front());
        if (m_served == BURST_LEN) rel = 1'b1;
      end
      if (rel) begin
        other    = 1 - m_own;
        m_fav    = other;
        m_own    = r[other] ? other : -1;
        m_served = 0;
      end
    end

    @(posedge clk);
    #1;
  endtask

  task automatic start_phase();
    wq0.delete();
    wq1.delete();
    tick(0, 0, 0, 0);
    clear_obs();
  endtask

  initial begin
    int fc;
    bit en0, en1, rst_n;

    reset    = 1'b0;
    req0     = 1'b0;
    req1     = 1'b0;
    data0    = '0;
    data1    = '0;
    fifo_cnt = '0;
    @(posedge clk);
    #1;

    // Lone requester: 4-word burst, one idle cycle, re-grant for the rest.
    start_phase();
    for (int i = 0; i < 6; i++) wq0.push_back(DATA_W'(8'hA0 + i));
    for (int c = 0; c < 10; c++) tick(1, 0, 0, 1);
    check("lone_grant_c1", 32'(obs_g[1]), 32'd1);
    check("lone_wr_c4",    32'(obs_wr[4]), 32'd1);
    check("lone_idle_c5",  32'(obs_g[5]), 32'd0);
    check("lone_regrant",  32'(obs_g[6]), 32'd1);
    check("lone_acks",     32'(ack_tot0), 32'd6);

    // Both requesting: owners alternate without an idle cycle.
    start_phase();
    for (int i = 0; i < 12; i++) begin
      wq0.push_back(DATA_W'($urandom));
      wq1.push_back(DATA_W'($urandom));
    end
    for (int c = 0; c < 13; c++) tick(1, 1, 0, 1);
    check("rr_first",  32'(obs_g[1]), 32'd1);
    check("rr_switch", 32'(obs_g[5]), 32'd2);
    check("rr_hold1",  32'(obs_g[8]), 32'd2);
    check("rr_back",   32'(obs_g[9]), 32'd1);
    check("rr_acks0",  32'(ack_tot0), 32'd8);
    check("rr_acks1",  32'(ack_tot1), 32'd4);

    // Full stall in OWN0, including an over-range occupancy value.
    start_phase();
    for (int i = 0; i < 8; i++) wq0.push_back(DATA_W'($urandom));
    tick(1, 0, 0, 1);
    tick(1, 0, 0, 1);
    tick(1, 0, 16, 1);
    tick(1, 0, 16, 1);
    tick(1, 0, 20, 1);
    tick(1, 0, 15, 1);
    tick(1, 0, 0, 1);
    tick(1, 0, 0, 1);
    tick(1, 0, 0, 1);
    check("stall_no_wr",  32'(obs_wr[3]), 32'd0);
    check("stall_over",   32'(obs_wr[4]), 32'd0);
    check("stall_held",   32'(obs_g[4]), 32'd1);
    check("stall_resume", 32'(obs_wr[5]), 32'd1);
    check("stall_burst4", 32'(obs_g[7]), 32'd1);
    check("stall_rel",    32'(obs_g[8]), 32'd0);

    // Requester 1 drops after two writes; requester 0 takes over with a full burst.
    start_phase();
    for (int i = 0; i < 2; i++) wq1.push_back(DATA_W'($urandom));
    for (int i = 0; i < 5; i++) wq0.push_back(DATA_W'($urandom));
    tick(0, 1, 0, 1);
    for (int c = 1; c < 9; c++) tick(1, 1, 0, 1);
    check("drop_no_wr",   32'(obs_wr[3]), 32'd0);
    check("drop_handoff", 32'(obs_g[4]), 32'd1);
    check("drop_full_b",  32'(obs_g[7]), 32'd1);
    check("drop_rel",     32'(obs_g[8]), 32'd0);
    check("drop_acks0",   32'(ack_tot0), 32'd4);

    // Reset pulsed mid-burst: no write in that cycle; requester 0 favoured after.
    start_phase();
    for (int i = 0; i < 6; i++) begin
      wq0.push_back(DATA_W'($urandom));
      wq1.push_back(DATA_W'($urandom));
    end
    for (int c = 0; c < 3; c++) tick(1, 1, 0, 1);
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 1);
    tick(1, 1, 0, 1);
    check("rst_grant",  32'(obs_g[3]), 32'd0);
    check("rst_no_wr",  32'(obs_wr[3]), 32'd0);
    check("rst_idle",   32'(obs_g[4]), 32'd0);
    check("rst_favour", 32'(obs_g[5]), 32'd1);

    // Ten writes from requester 0 for the statistics counters.
    start_phase();
    for (int i = 0; i < 10; i++) wq0.push_back(DATA_W'($urandom));
    for (int c = 0; c < 16; c++) tick(1, 0, 0, 1);
    check("stat_acks", 32'(ack_tot0), 32'd10);
`ifdef FIFO_WR_ARB_STATS_EN
    check("stat_wc0", 32'(wr_count0), 32'd10);
`else
    check("stat_wc0", 32'(wr_count0), 32'd0);
`endif
    check("stat_wc1", 32'(wr_count1), 32'd0);

    // Randomized traffic: request drops, stalls, over-range counts, resets.
    start_phase();
    en0 = 1'b1;
    en1 = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) en0 = ~en0;
      if ($urandom_range(0, 7) == 0) en1 = ~en1;
      if (wq0.size() < 4 && $urandom_range(0, 2) == 0) wq0.push_back(DATA_W'($urandom));
      if (wq1.size() < 4 && $urandom_range(0, 2) == 0) wq1.push_back(DATA_W'($urandom));
      fc    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 31)) : int'($urandom_range(0, 13));
      rst_n = ($urandom_range(0, 249) != 0);
      tick(en0, en1, fc, rst_n);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
